// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and one responder (slave).
// Pure wiring, no latency of its own.
// Backpressure is carried by PREADY from the slave.
interface apb_slave_regfile_if;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB responder: 16 x 32-bit register bank (reg0 = ID, reg15 = transfer count).
// Latency: PREADY first high in access-phase cycle WAIT_STATES+1 (setup + WAIT_STATES + 1).
// Backpressure: PREADY held low for WAIT_STATES access cycles; outputs come from flops only.
module apb_slave_regfile #(
    parameter int unsigned SEL_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    apb_slave_regfile_if.slave   apb
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_wait_cnt;
    logic        r_write;
    logic [3:0]  r_idx;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_prdata;
    logic [31:0] r_regs [16];
    logic [31:0] r_count;

    logic        w_sel;
    logic        w_setup;
    logic        w_ready;
    logic        w_commit;
    logic        w_count_inc;
    logic [3:0]  w_idx;
    logic        w_err;
    logic [31:0] w_rd_val;
    logic        w_unused_psel;

    assign w_sel         = apb.PSEL[SEL_IDX];
    assign w_unused_psel = ^apb.PSEL;
    assign w_idx         = apb.PADDR[5:2];

    // Misaligned, outside our 64-byte window, or a write to a read-only slot.
    assign w_err = (apb.PADDR[1:0] != 2'b00)
                 | (apb.PADDR[31:6] != BASE_ADDR[31:6])
                 | (apb.PWRITE && ((w_idx == 4'd0) || (w_idx == 4'd15)));

    assign w_commit    = w_ready && r_write && !r_err;
    assign w_count_inc = w_ready && !r_err;

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; PREADY depends only on state and the wait counter.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_setup     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel && !apb.PENABLE) begin
                    w_setup     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_wait_cnt == 4'd0) begin
                    w_ready = 1'b1;
                    if (w_sel && !apb.PENABLE) begin
                        w_setup     = 1'b1;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read value, forwarding a write or count bump that commits on the same edge.
    always_comb begin
        w_rd_val = '0;
        if (w_idx == 4'd0)
            w_rd_val = ID_VALUE;
        else if (w_idx == 4'd15)
            w_rd_val = w_count_inc ? (r_count + 32'd1) : r_count;
        else if (w_commit && (r_idx == w_idx))
            w_rd_val = r_wdata;
        else
            w_rd_val = r_regs[w_idx];
    end

    // Capture the setup phase, run the wait counter, drop PRDATA after completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wait_cnt <= '0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_prdata   <= '0;
        end else if (w_setup) begin
            r_wait_cnt <= LP_WAIT;
            r_write    <= apb.PWRITE;
            r_idx      <= w_idx;
            r_wdata    <= apb.PWDATA;
            r_err      <= w_err;
            r_prdata   <= (!apb.PWRITE && !w_err) ? w_rd_val : '0;
        end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end else if (w_ready) begin
            r_prdata   <= '0;
        end
    end

    // Register bank; slots 0 and 15 are never written here (writes to them are errors).
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_idx] <= r_wdata;
        end
    end

    // Transfer counter: every error-free completion, wraps naturally.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)           r_count <= '0;
        else if (w_count_inc) r_count <= r_count + 32'd1;
    end

    assign apb.PREADY  = w_ready;
    assign apb.PSLVERR = w_ready & r_err;
    assign apb.PRDATA  = r_prdata;

endmodule
